// File: rtl/issue_buffer.sv
// issue_buffer: in-order queue between the decoder and the reservation stations.
// Operands are captured from the register bank at enqueue, pending tags are
// resolved by snooping the CDB, and the head issues with a same-cycle rename
// write into the bank.
module issue_buffer #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int REG_W  = 5,
  parameter int OP_W   = 5,
  parameter int DEPTH  = 4,
  parameter logic [TAG_W-1:0] INVALID_TAG = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_W-1:0]              in_operator_type,
  input  logic [REG_W-1:0]             in_reg_1,
  input  logic [REG_W-1:0]             in_reg_2,
  input  logic [REG_W-1:0]             in_reg_3,
  output logic [REG_W-1:0]             out_reg_1,
  output logic [REG_W-1:0]             out_reg_2,
  input  logic [DATA_W-1:0]            in_val_1,
  input  logic [DATA_W-1:0]            in_val_2,
  input  logic [TAG_W-1:0]             in_tag_1,
  input  logic [TAG_W-1:0]             in_tag_2,
  input  logic                         in_cdb_valid,
  input  logic [TAG_W-1:0]             in_cdb_tag,
  input  logic [DATA_W-1:0]            in_cdb_val,
  output logic                         out_rs_valid,
  input  logic                         in_rs_ready,
  input  logic [TAG_W-1:0]             in_rs_tag,
  output logic [OP_W-1:0]              out_operator_type,
  output logic [DATA_W-1:0]            out_val_1,
  output logic [DATA_W-1:0]            out_val_2,
  output logic [TAG_W-1:0]             out_tag_1,
  output logic [TAG_W-1:0]             out_tag_2,
  output logic                         out_bank_enable,
  output logic [REG_W-1:0]             out_bank_reg,
  output logic [TAG_W-1:0]             out_bank_tag,
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  r1;
    logic [REG_W-1:0]  r2;
    logic [REG_W-1:0]  r3;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  t1;
    logic [TAG_W-1:0]  t2;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  entry_t head, enq_e;
  logic   enq, iss;

  // A tag equal to INVALID_TAG means "value present" and never matches the CDB.
  function automatic logic cdb_hit(input logic v, input logic [TAG_W-1:0] ct,
                                   input logic [TAG_W-1:0] t);
    return v && (t == ct) && (t != INVALID_TAG);
  endfunction

  assign in_ready        = (count_q != CNT_W'(DEPTH));
  assign out_rs_valid    = (count_q != '0);
  assign enq             = in_valid && in_ready;
  assign iss             = out_rs_valid && in_rs_ready;
  assign head            = mem_q[head_q];
  assign out_reg_1       = in_reg_1;
  assign out_reg_2       = in_reg_2;
  assign out_count       = count_q;
  assign out_bank_enable = iss;
  assign out_bank_reg    = head.r3;
  assign out_bank_tag    = in_rs_tag;

  // Head fields with same-cycle CDB forwarding so a just-resolved operand issues as a value.
  always_comb begin
    out_operator_type = head.op;
    out_val_1         = head.v1;
    out_tag_1         = head.t1;
    out_val_2         = head.v2;
    out_tag_2         = head.t2;
    if (cdb_hit(in_cdb_valid, in_cdb_tag, head.t1)) begin
      out_val_1 = in_cdb_val;
      out_tag_1 = INVALID_TAG;
    end
    if (cdb_hit(in_cdb_valid, in_cdb_tag, head.t2)) begin
      out_val_2 = in_cdb_val;
      out_tag_2 = INVALID_TAG;
    end
  end

  // Incoming entry: bank data, then CDB bypass, then rename override from a concurrent issue.
  always_comb begin
    enq_e.op = in_operator_type;
    enq_e.r1 = in_reg_1;
    enq_e.r2 = in_reg_2;
    enq_e.r3 = in_reg_3;
    enq_e.v1 = in_val_1;
    enq_e.v2 = in_val_2;
    enq_e.t1 = in_tag_1;
    enq_e.t2 = in_tag_2;
    if (cdb_hit(in_cdb_valid, in_cdb_tag, in_tag_1)) begin
      enq_e.v1 = in_cdb_val;
      enq_e.t1 = INVALID_TAG;
    end
    if (cdb_hit(in_cdb_valid, in_cdb_tag, in_tag_2)) begin
      enq_e.v2 = in_cdb_val;
      enq_e.t2 = INVALID_TAG;
    end
    if (iss && (in_reg_1 == head.r3)) enq_e.t1 = in_rs_tag;
    if (iss && (in_reg_2 == head.r3)) enq_e.t2 = in_rs_tag;
  end

  // Next state: snoop every slot, then let the issuing rename win, then write the tail.
  // The popped head may also be touched here; it is dead after the edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (cdb_hit(in_cdb_valid, in_cdb_tag, mem_q[i].t1)) begin
        mem_d[i].v1 = in_cdb_val;
        mem_d[i].t1 = INVALID_TAG;
      end
      if (cdb_hit(in_cdb_valid, in_cdb_tag, mem_q[i].t2)) begin
        mem_d[i].v2 = in_cdb_val;
        mem_d[i].t2 = INVALID_TAG;
      end
      if (iss && (mem_q[i].r1 == head.r3)) mem_d[i].t1 = in_rs_tag;
      if (iss && (mem_q[i].r2 == head.r3)) mem_d[i].t2 = in_rs_tag;
      // Enqueue only fires when not full, so the tail slot never holds a live entry.
      if (enq && (tail_q == PTR_W'(i))) mem_d[i] = enq_e;
    end
    head_d  = iss ? head_q + PTR_W'(1) : head_q;
    tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(enq) - CNT_W'(iss);
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless outside [head, head+count).
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

endmodule

// File: doc/issue_buffer.md
# issue_buffer

Parametrised in-order issue buffer for the Tomasulo core. It sits between the instruction decoder and the reservation stations. It queues up to DEPTH decoded instructions, and at enqueue it captures operand values or producer tags from the register bank. While entries wait, it snoops the CDB to resolve pending tags. It issues the head instruction to a reservation station over a valid/ready handshake and writes the allocated RS tag into the register bank in the same cycle.

## Interface
- DATA_W, 32, operand/CDB value width
- TAG_W, 5, RS tag width
- REG_W, 5, architectural register index width
- OP_W, 5, operator-type width
- DEPTH, 4, queue entries; power of two, >= 2
- INVALID_TAG, all ones (TAG_W bits), "value present" marker; never matched against the CDB
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoder offers an instruction
- in_ready  out  1  buffer accepts it: !full
- in_operator_type / in_reg_1 / in_reg_2 / in_reg_3  in  OP_W / REG_W×3  opcode, sources, destination
- out_reg_1 / out_reg_2  out  REG_W  bank read addresses; combinational copies of in_reg_1/2
- in_val_1 / in_val_2  in  DATA_W  bank read data, same cycle
- in_tag_1 / in_tag_2  in  TAG_W  bank pending-producer tags, same cycle; INVALID_TAG means the value is valid
- in_cdb_valid  in  1  CDB broadcast this cycle
- in_cdb_tag / in_cdb_val  in  TAG_W / DATA_W  broadcast tag and value
- out_rs_valid  out  1  head entry offered to the RS: !empty
- in_rs_ready  in  1  RS has a free slot
- in_rs_tag  in  TAG_W  tag of that free slot; valid while in_rs_ready
- out_operator_type, out_val_1/2, out_tag_1/2  out  OP_W, DATA_W, TAG_W  head fields after CDB forwarding
- out_bank_enable / out_bank_reg / out_bank_tag  out  1 / REG_W / TAG_W  rename write: reg[in_reg_3 of head] <= in_rs_tag
- out_count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Storage is a circular FIFO: head and tail pointers of log2(DEPTH) bits that wrap naturally, plus the count. Each entry holds op, reg_1, reg_2, reg_3, val_1, val_2, tag_1, tag_2.
- Enqueue fires when in_valid && in_ready. The entry takes the bank read data, with these per-operand corrections applied in order:
  - (a) CDB bypass: if in_cdb_valid and in_tag_n == in_cdb_tag != INVALID_TAG, then val = in_cdb_val and tag = INVALID_TAG.
  - (b) Rename override: if an issue fires this cycle and in_reg_n == head reg_3, then tag = in_rs_tag.
- Snoop: every cycle with in_cdb_valid, each stored entry whose tag_n == in_cdb_tag (and tag_n != INVALID_TAG) loads val_n = in_cdb_val and sets tag_n = INVALID_TAG.
- Issue fires when out_rs_valid && in_rs_ready. At the same edge:
  - the head pops;
  - every remaining entry whose reg_n equals the head's reg_3 gets tag_n = in_rs_tag. This applies after the snoop, so the override wins.
- Head outputs are combinational from the head entry, with the CDB bypass of (a) applied. An operand resolved in the issue cycle is therefore sent as a value.
- out_bank_enable = issue fire (combinational). out_bank_reg = head reg_3. out_bank_tag = in_rs_tag. The bank writes at the same edge.
- Simultaneous enqueue and issue: both happen; count is unchanged.
- When full, in_ready = 0. There is no same-cycle pop-through.

## Timing
- Reset (rst high at an edge): count, head and tail = 0; out_rs_valid = 0; in_ready = 1; out_bank_enable = 0. Entry contents are don't-care. Reset overrides any enqueue or issue in that cycle.
- Latency: an instruction enqueued at edge k is at out_rs_valid by cycle k+1 at the earliest. There is no empty-queue bypass.
- Throughput: one enqueue and one issue per cycle.
- out_reg_1/2 and the head outputs are combinational. All state updates on the rising clk edge.
- Issuing a single instruction whose own source equals its destination is legal. The rename override applies only to entries still in the queue after the pop.

## Test plan
- Reset then idle: out_rs_valid = 0, in_ready = 1, out_count = 0, out_bank_enable = 0.
- Fill DEPTH=4 with in_rs_ready = 0:
  - in_ready drops after the 4th accept and out_count = 4.
  - Raise in_rs_ready with in_rs_tag 1,2,3,4 per cycle: issue order matches enqueue order, out_bank_enable is high for 4 cycles, out_bank_tag = 1..4.
- CDB snoop:
  - Enqueue op with in_tag_1 = 3.
  - Broadcast tag 3, value 0xDEAD_BEEF while queued.
  - Issue: out_val_1 = 0xDEADBEEF, out_tag_1 = INVALID_TAG.
- Same-cycle CDB:
  - Head tag_2 = 7; assert CDB tag 7, value 0x55 in the issue cycle.
  - Issued out_val_2 = 0x55, out_tag_2 = INVALID_TAG.
  - Repeat with tag 7 broadcast during the enqueue cycle: the entry is stored resolved.
- Rename hazard:
  - Queue A (r3 <= r1 op r2), then B (r4 <= r3 op r5); bank r3 tag = INVALID_TAG.
  - A issues with in_rs_tag = 9: B's tag_1 becomes 9. Also repeat with B enqueued in A's issue cycle: B's tag_1 = 9.
- Wrap and mid-operation reset:
  - Run 10 enqueue/issue pairs through the buffer: order is preserved across pointer wrap.
  - Assert rst with out_count = 3: the next cycle has out_count = 0, out_rs_valid = 0, and no bank write.
